// File: rtl/clock_time_counter_pkg.sv
// Shared definitions for the clock time counter: mode encodings, field width and wrap values.
package clock_time_counter_pkg;

  localparam int unsigned FIELD_W = 6;

  localparam logic [1:0] MODE_RUN      = 2'd0;
  localparam logic [1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [1:0] MODE_SET_MIN  = 2'd2;
  localparam logic [1:0] MODE_SET_SEC  = 2'd3;

  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/clock_time_counter_mod_counter.sv
// Modulo-(MAX+1) counter for one time field; carry flags that the next increment wraps.
module clock_time_counter_mod_counter
  import clock_time_counter_pkg::*;
#(
  parameter int unsigned       WIDTH = FIELD_W,
  parameter logic [WIDTH-1:0]  MAX   = SEC_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  logic [WIDTH-1:0] value_q;

  assign carry = (value_q == MAX);
  assign value = value_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (en) begin
      value_q <= carry ? '0 : value_q + 1'b1;
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Timekeeping stage: 1 Hz prescaler, hour/min/sec counters and a mode FSM for setting the time.
module clock_time_counter
  import clock_time_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_btn,
  input  logic               inc_btn,
  output logic [FIELD_W-1:0] hour_bin,
  output logic [FIELD_W-1:0] min_bin,
  output logic [FIELD_W-1:0] sec_bin,
  output logic [1:0]         mode,
  output logic               day_pulse
);

  localparam int unsigned   PW        = $clog2(PRESCALE);
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    mode_q, mode_d;
  logic          day_pulse_q;
  logic          run, tick;
  logic          sec_en, min_en, hour_en;
  logic          sec_carry, min_carry, hour_carry;

  assign run  = (mode_q == MODE_RUN);
  assign tick = run && (pcnt_q == PCNT_LAST);

  always_comb begin
    pcnt_d = '0;
    if (run && !tick) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_btn) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_d = MODE_SET_MIN;
        MODE_SET_MIN:  mode_d = MODE_SET_SEC;
        MODE_SET_SEC:  mode_d = MODE_RUN;
        default:       mode_d = MODE_RUN;
      endcase
    end
  end

  // RUN follows the tick/carry chain; set states bump only the selected field, no carry.
  always_comb begin
    if (run) begin
      sec_en  = tick;
      min_en  = tick && sec_carry;
      hour_en = tick && sec_carry && min_carry;
    end else begin
      sec_en  = inc_btn && (mode_q == MODE_SET_SEC);
      min_en  = inc_btn && (mode_q == MODE_SET_MIN);
      hour_en = inc_btn && (mode_q == MODE_SET_HOUR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q      <= '0;
      mode_q      <= MODE_RUN;
      day_pulse_q <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      mode_q      <= mode_d;
      day_pulse_q <= hour_en && run && hour_carry;
    end
  end

  clock_time_counter_mod_counter #(
    .WIDTH (FIELD_W),
    .MAX   (SEC_MAX)
  ) u_sec (
    .clk   (clk),
    .reset (reset),
    .en    (sec_en),
    .value (sec_bin),
    .carry (sec_carry)
  );

  clock_time_counter_mod_counter #(
    .WIDTH (FIELD_W),
    .MAX   (MIN_MAX)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .en    (min_en),
    .value (min_bin),
    .carry (min_carry)
  );

  clock_time_counter_mod_counter #(
    .WIDTH (FIELD_W),
    .MAX   (FIELD_W'(HOUR_MAX))
  ) u_hour (
    .clk   (clk),
    .reset (reset),
    .en    (hour_en),
    .value (hour_bin),
    .carry (hour_carry)
  );

  assign mode      = mode_q;
  assign day_pulse = day_pulse_q;

endmodule
